// File: rtl/regfile_write_controller.sv
// Write-port controller for the LITE-16 register file.
// Arbitrates the single write port between execute writeback (EX) and load
// return (LD), stages the winning write for one cycle onto rf_en/rf_data,
// tracks outstanding loads in a per-register scoreboard and raises a
// combinational decode stall (hazard).
//
// Arbitration pointer
//   state   | meaning
//   PRIO_EX | EX wins when both ports are eligible (reset value)
//   PRIO_LD | LD wins when both ports are eligible
module regfile_write_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [ADDR_W-1:0]        ex_addr,
    input  logic [DATA_W-1:0]        ex_data,

    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,

    input  logic                     iss_ld,
    input  logic [ADDR_W-1:0]        iss_addr,

    input  logic [ADDR_W-1:0]        src_a,
    input  logic [ADDR_W-1:0]        src_b,
    input  logic [ADDR_W-1:0]        src_d,
    input  logic                     use_a,
    input  logic                     use_b,
    input  logic                     use_d,

    output logic [(1<<ADDR_W)-1:0]   rf_en,
    output logic [DATA_W-1:0]        rf_data,
    output logic [(1<<ADDR_W)-1:0]   pend,
    output logic                     hazard
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {
        PRIO_EX = 1'b0,
        PRIO_LD = 1'b1
    } prio_t;

    prio_t            prio;
    logic             ex_elig;
    logic             ld_elig;
    logic             grant_ex;
    logic             grant_ld;
    logic             ex_accept;
    logic             ld_accept;
    logic             issue_ok;
    logic [NREG-1:0]  busy_vec;
    logic [NREG-1:0]  pend_next;

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // An EX write to a register with a load still outstanding must wait for
    // that load, otherwise the late load return would overwrite the newer value.
    assign ex_elig   = ex_valid && !pend[ex_addr];
    assign ld_elig   = ld_valid;

    assign grant_ex  = ex_elig && (!ld_elig || (prio == PRIO_EX));
    assign grant_ld  = ld_elig && (!ex_elig || (prio == PRIO_LD));

    assign ex_ready  = grant_ex && !pend[ex_addr];
    assign ld_ready  = grant_ld;

    assign ex_accept = ex_valid && ex_ready;
    assign ld_accept = ld_valid && ld_ready;

    // A register is unsafe to read while a load to it is outstanding, while a
    // write to it sits in the stage register, or while a requester targets it.
    assign busy_vec  = pend
                     | rf_en
                     | (ex_valid ? onehot(ex_addr) : '0)
                     | (ld_valid ? onehot(ld_addr) : '0);

    assign hazard    = (use_a && busy_vec[src_a])
                    || (use_b && busy_vec[src_b])
                    || (use_d && busy_vec[src_d])
                    || (iss_ld && (pend[iss_addr] || rf_en[iss_addr]));

    // A stalled issue is dropped; the issue stage retries it.
    assign issue_ok  = iss_ld && !hazard;

    // Next scoreboard: load return clears, unblocked issue sets.
    always_comb begin
        pend_next = pend;
        if (ld_accept) begin
            pend_next[ld_addr] = 1'b0;
        end
        if (issue_ok) begin
            pend_next[iss_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Write stage: present the accepted write for exactly one cycle; data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en   <= '0;
            rf_data <= '0;
        end else if (ex_accept) begin
            rf_en   <= onehot(ex_addr);
            rf_data <= ex_data;
        end else if (ld_accept) begin
            rf_en   <= onehot(ld_addr);
            rf_data <= ld_data;
        end else begin
            rf_en   <= '0;
        end
    end

    // Round-robin pointer: after a transfer the other port gets precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= PRIO_EX;
        end else if (ex_accept) begin
            prio <= PRIO_LD;
        end else if (ld_accept) begin
            prio <= PRIO_EX;
        end
    end

endmodule

// File: tb/tb_regfile_write_controller.sv
// Self-checking bench for regfile_write_controller: directed scenarios with
// literal expectations followed by randomized traffic against a model.
`timescale 1ns/1ps
module tb_regfile_write_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_addr;
    logic [15:0] ex_data;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic        iss_ld;
    logic [3:0]  iss_addr;
    logic [3:0]  src_a, src_b, src_d;
    logic        use_a, use_b, use_d;
    logic [15:0] rf_en, rf_data, pend;
    logic        hazard;

    regfile_write_controller #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .iss_ld(iss_ld), .iss_addr(iss_addr),
        .src_a(src_a), .src_b(src_b), .src_d(src_d),
        .use_a(use_a), .use_b(use_b), .use_d(use_d),
        .rf_en(rf_en), .rf_data(rf_data), .pend(pend), .hazard(hazard)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend[16];     // outstanding loads per register
    int          m_stage;        // register being written this cycle, -1 if none
    logic [15:0] m_data;         // last staged data
    bit          m_last_ex;      // last served port was EX
    bit          m_gex, m_gld, m_hz;

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_stage   = -1;
        m_data    = 16'h0;
        m_last_ex = 1'b0;
    endtask

    function automatic bit busy(input logic [3:0] s);
        return m_pend[s] || (m_stage == int'(s))
            || (ex_valid && ex_addr == s) || (ld_valid && ld_addr == s);
    endfunction

    task automatic model_eval();
        bit ex_el, ld_el;
        ex_el = ex_valid && !m_pend[ex_addr];
        ld_el = ld_valid;
        if (ex_el && ld_el) begin
            m_gex = !m_last_ex;
            m_gld = m_last_ex;
        end else begin
            m_gex = ex_el;
            m_gld = ld_el;
        end
        m_hz = (use_a && busy(src_a)) || (use_b && busy(src_b)) || (use_d && busy(src_d))
            || (iss_ld && (m_pend[iss_addr] || m_stage == int'(iss_addr)));
    endtask

    task automatic model_step();
        model_eval();
        if (m_gex) begin
            m_stage = int'(ex_addr);
            m_data  = ex_data;
        end else if (m_gld) begin
            m_stage = int'(ld_addr);
            m_data  = ld_data;
        end else begin
            m_stage = -1;
        end
        if (m_gld) m_pend[ld_addr] = 1'b0;
        if (iss_ld && !m_hz) m_pend[iss_addr] = 1'b1;
        if (m_gex) m_last_ex = 1'b1;
        else if (m_gld) m_last_ex = 1'b0;
    endtask

    function automatic logic [15:0] exp_pend();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [15:0] exp_en();
        logic [15:0] v;
        v = 16'h0;
        if (m_stage >= 0) v[m_stage] = 1'b1;
        return v;
    endfunction

    // Compare process: check at falling edge, advance model at rising edge.
    initial begin : compare
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            model_eval();
            chk("ex_ready", 32'(ex_ready), 32'(m_gex));
            chk("ld_ready", 32'(ld_ready), 32'(m_gld));
            chk("hazard",   32'(hazard),   32'(m_hz));
            chk("rf_en",    32'(rf_en),    32'(exp_en()));
            chk("rf_data",  32'(rf_data),  32'(m_data));
            chk("pend",     32'(pend),     32'(exp_pend()));
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_addr = 0; ex_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        iss_ld = 0; iss_addr = 0;
        src_a = 0; src_b = 0; src_d = 0;
        use_a = 0; use_b = 0; use_d = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [15:0] exp_seq[4];
    bit          ex_took, ld_took;
    int          q[$];

    initial begin : main
        exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0004;
        exp_seq[2] = 16'h0002; exp_seq[3] = 16'h0004;
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // reset state
        at_neg();
        chk("rst_rf_en", 32'(rf_en), 32'h0);
        chk("rst_rf_data", 32'(rf_data), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);

        // single EX write
        cyc();
        ex_valid = 1; ex_addr = 4'd3; ex_data = 16'hBEEF;
        at_neg(); chk("t1_ex_ready", 32'(ex_ready), 32'h1);
        cyc(); ex_valid = 0;
        at_neg(); chk("t1_rf_en", 32'(rf_en), 32'h0008); chk("t1_rf_data", 32'(rf_data), 32'hBEEF);
        cyc();
        at_neg(); chk("t1_rf_en_clr", 32'(rf_en), 32'h0);

        // contention after reset: EX, LD, EX, LD
        do_reset();
        ex_valid = 1; ex_addr = 4'd1; ex_data = 16'h1111;
        ld_valid = 1; ld_addr = 4'd2; ld_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("t2_ex_ready", 32'(ex_ready), 32'((i % 2) == 0));
            chk("t2_ld_ready", 32'(ld_ready), 32'((i % 2) == 1));
            if (i > 0) chk("t2_rf_en", 32'(rf_en), 32'(exp_seq[i-1]));
            cyc();
        end
        ex_valid = 0; ld_valid = 0;
        at_neg(); chk("t2_rf_en_last", 32'(rf_en), 32'(exp_seq[3]));

        // scoreboard and WAW
        cyc(); iss_ld = 1; iss_addr = 4'd5;
        cyc(); iss_ld = 0;
        at_neg(); chk("t3_pend_set", 32'(pend), 32'h0020);
        cyc(); src_a = 4'd5; use_a = 1; ex_valid = 1; ex_addr = 4'd5; ex_data = 16'h5555;
        at_neg(); chk("t3_hazard", 32'(hazard), 32'h1); chk("t3_ex_blocked", 32'(ex_ready), 32'h0);
        cyc(); ld_valid = 1; ld_addr = 4'd5; ld_data = 16'hAAAA;
        at_neg(); chk("t3_ld_ready", 32'(ld_ready), 32'h1); chk("t3_ex_still", 32'(ex_ready), 32'h0);
        cyc(); ld_valid = 0;
        at_neg(); chk("t3_pend_clr", 32'(pend), 32'h0); chk("t3_ex_ready", 32'(ex_ready), 32'h1);
        chk("t3_ld_write", 32'(rf_data), 32'hAAAA);
        cyc(); ex_valid = 0; use_a = 0;
        at_neg(); chk("t3_ex_write_en", 32'(rf_en), 32'h0020); chk("t3_ex_write", 32'(rf_data), 32'h5555);

        // blocked issue
        cyc(); iss_ld = 1; iss_addr = 4'd7;
        cyc(); iss_ld = 0;
        at_neg(); chk("t4_pend", 32'(pend), 32'h0080);
        cyc(); iss_ld = 1; iss_addr = 4'd7;
        at_neg(); chk("t4_hazard_pend", 32'(hazard), 32'h1);
        cyc(); iss_ld = 0;
        at_neg(); chk("t4_pend_kept", 32'(pend), 32'h0080);
        cyc(); ld_valid = 1; ld_addr = 4'd7; ld_data = 16'h7777;
        cyc(); ld_valid = 0; iss_ld = 1; iss_addr = 4'd7;
        at_neg(); chk("t4_staged", 32'(rf_en), 32'h0080); chk("t4_hazard_staged", 32'(hazard), 32'h1);
        cyc(); iss_ld = 0;
        at_neg(); chk("t4_pend_none", 32'(pend), 32'h0);

        // in-flight hazard
        cyc(); ex_valid = 1; ex_addr = 4'd9; ex_data = 16'h9999; src_b = 4'd9; use_b = 1;
        at_neg(); chk("t5_hz_accept", 32'(hazard), 32'h1); chk("t5_ex_ready", 32'(ex_ready), 32'h1);
        cyc(); ex_valid = 0;
        at_neg(); chk("t5_rf_en", 32'(rf_en), 32'h0200); chk("t5_hz_stage", 32'(hazard), 32'h1);
        cyc();
        at_neg(); chk("t5_hz_done", 32'(hazard), 32'h0);
        cyc(); use_b = 0; ex_valid = 1;
        at_neg(); chk("t5_nouse_a", 32'(hazard), 32'h0);
        cyc(); ex_valid = 0;
        at_neg(); chk("t5_nouse_b", 32'(hazard), 32'h0);
        cyc();
        at_neg(); chk("t5_nouse_c", 32'(hazard), 32'h0);

        // asynchronous reset between edges
        cyc(); iss_ld = 1; iss_addr = 4'd4; ex_valid = 1; ex_addr = 4'd2; ex_data = 16'h2B2B;
        cyc(); iss_ld = 0; ex_valid = 0;
        #1;
        chk("t6_pre_pend", 32'(pend), 32'h0010); chk("t6_pre_en", 32'(rf_en), 32'h0004);
        #1 rst = 1'b1;
        #1;
        chk("t6_rf_en", 32'(rf_en), 32'h0); chk("t6_rf_data", 32'(rf_data), 32'h0);
        chk("t6_pend", 32'(pend), 32'h0);
        cyc(); cyc(); rst = 1'b0;
        ex_valid = 1; ex_addr = 4'd1; ex_data = 16'h1111;
        ld_valid = 1; ld_addr = 4'd2; ld_data = 16'h2222;
        at_neg(); chk("t6_ex_first", 32'(ex_ready), 32'h1); chk("t6_ld_wait", 32'(ld_ready), 32'h0);
        cyc();
        at_neg(); chk("t6_ld_second", 32'(ld_ready), 32'h1);
        cyc(); ex_valid = 0; ld_valid = 0;

        // randomized traffic, requesters hold until accepted
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ex_took = ex_valid && ex_ready;
            ld_took = ld_valid && ld_ready;
            cyc();
            if (!ex_valid || ex_took) begin
                ex_valid = ($urandom_range(0, 9) < 6);
                ex_addr  = 4'($urandom);
                ex_data  = 16'($urandom);
            end
            if (!ld_valid || ld_took) begin
                q.delete();
                for (int i = 0; i < 16; i++) if (m_pend[i]) q.push_back(i);
                ld_valid = ($urandom_range(0, 9) < 5);
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    ld_addr = 4'(q[$urandom_range(0, q.size() - 1)]);
                else
                    ld_addr = 4'($urandom);
                ld_data = 16'($urandom);
            end
            iss_ld   = ($urandom_range(0, 9) < 3);
            iss_addr = 4'($urandom);
            src_a = 4'($urandom); src_b = 4'($urandom); src_d = 4'($urandom);
            use_a = 1'($urandom); use_b = 1'($urandom); use_d = 1'($urandom);
        end
        idle_inputs();
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
